// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: packs big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and bit length, then bursts each block to the core.
module sha256_msg_padder #(
    parameter int LEN_W      = 64,
    parameter int MIN_GAP    = 2,
    parameter int FIRST_LEAD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ready,
    input  logic        core_busy,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        first_block,
    output logic        last_block,
    output logic        msg_done
);

    localparam int GW = $clog2(MIN_GAP + 2);

    typedef enum logic [2:0] {S_FILL, S_PAD, S_HOLD, S_SEND, S_GAP} state_t;

    state_t           r_state, w_next;
    logic [4:0]       r_wptr;
    logic [3:0]       r_scnt;
    logic [GW-1:0]    r_gcnt;
    logic [LEN_W-1:0] r_len;
    logic             r_first, r_pad80, r_lenblk, r_pend, r_blast;
    logic [31:0]      r_buf [16];
    logic             r_ready, r_we, r_fb, r_lb, r_done;
    logic [31:0]      r_data;

    logic             w_accept, w_blk_done, w_pad_last, w_enter_send;
    logic [2:0]       w_nb;
    logic [31:0]      w_word, w_padword;
    logic [63:0]      w_len64;
    logic [LEN_W-1:0] w_len_add;

    assign w_accept     = r_ready && in_valid && (r_state == S_FILL);
    assign w_nb         = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    assign w_len_add    = in_last ? LEN_W'({w_nb, 3'b000}) : LEN_W'(32);
    assign w_len64      = 64'(r_len);
    assign w_blk_done   = (w_accept && !in_last && (r_wptr == 5'd15)) ||
                          ((r_state == S_PAD) && (r_wptr >= 5'd15));
    // Block closes as the final one only if the length landed in slots 14/15.
    assign w_pad_last   = (r_wptr == 5'd15) && !r_pad80 && r_lenblk;
    assign w_enter_send = (w_next == S_SEND) && (r_state != S_SEND);

    always_comb begin
        w_word = in_data;
        if (in_last) begin
            case (in_bytes)
                2'd1:    w_word = {in_data[31:24], 8'h80, 16'h0000};
                2'd2:    w_word = {in_data[31:16], 8'h80, 8'h00};
                2'd3:    w_word = {in_data[31:8], 8'h80};
                default: w_word = in_data;
            endcase
        end
    end

    always_comb begin
        w_padword = 32'h0000_0000;
        if (r_pad80)
            w_padword = 32'h8000_0000;
        else if (r_lenblk && (r_wptr == 5'd14))
            w_padword = w_len64[63:32];
        else if (r_lenblk && (r_wptr == 5'd15))
            w_padword = w_len64[31:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (in_last)
                        w_next = S_PAD;
                    else if (w_blk_done)
                        w_next = core_busy ? S_HOLD : S_SEND;
                end
            end
            S_PAD:  if (w_blk_done) w_next = core_busy ? S_HOLD : S_SEND;
            S_HOLD: if (!core_busy) w_next = S_SEND;
            S_SEND: if (r_scnt == 4'd15) w_next = S_GAP;
            S_GAP:  if ((r_gcnt >= GW'(MIN_GAP)) && !core_busy) w_next = r_pend ? S_PAD : S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_scnt   <= '0;
            r_gcnt   <= '0;
            r_len    <= '0;
            r_first  <= 1'b1;
            r_pad80  <= 1'b0;
            r_lenblk <= 1'b0;
            r_pend   <= 1'b0;
            r_blast  <= 1'b0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_data   <= '0;
            r_fb     <= 1'b0;
            r_lb     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ready <= (w_next == S_FILL);
            r_we    <= 1'b0;
            r_data  <= '0;
            r_fb    <= 1'b0;
            r_lb    <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_wptr <= r_wptr + 5'd1;
                        r_len  <= r_len + w_len_add;
                        if (in_last) begin
                            r_pad80  <= (w_nb == 3'd4);
                            r_lenblk <= (w_nb != 3'd4) && (r_wptr <= 5'd13);
                        end
                        if (w_blk_done) begin
                            r_blast <= 1'b0;
                            r_pend  <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    if (!r_wptr[4]) begin
                        r_wptr <= r_wptr + 5'd1;
                        if (r_pad80) begin
                            r_pad80  <= 1'b0;
                            r_lenblk <= (r_wptr <= 5'd13);
                        end
                    end
                    if (w_blk_done) begin
                        r_blast <= w_pad_last;
                        r_pend  <= !w_pad_last;
                    end
                end
                S_SEND: begin
                    r_scnt <= r_scnt + 4'd1;
                    r_we   <= 1'b1;
                    r_data <= r_buf[r_scnt];
                    if (r_scnt == 4'd0) begin
                        r_fb <= r_first;
                        r_lb <= r_blast;
                    end
                    if (r_scnt == 4'd15) begin
                        r_first <= 1'b0;
                        r_wptr  <= '0;
                        r_gcnt  <= '0;
                    end
                end
                S_GAP: begin
                    if (r_gcnt < GW'(MIN_GAP))
                        r_gcnt <= r_gcnt + GW'(1);
                    // Pending length block starts a fresh all-zero fill that carries the length.
                    if (w_next == S_PAD) begin
                        r_lenblk <= 1'b1;
                        r_pend   <= 1'b0;
                    end else if ((w_next == S_FILL) && r_blast) begin
                        r_done  <= 1'b1;
                        r_len   <= '0;
                        r_first <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_enter_send) begin
                r_scnt <= '0;
                if (FIRST_LEAD != 0)
                    r_fb <= r_first;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_wptr[3:0]] <= w_word;
        else if ((r_state == S_PAD) && !r_wptr[4])
            r_buf[r_wptr[3:0]] <= w_padword;
    end

    assign in_ready     = r_ready;
    assign data         = r_data;
    assign write_enable = r_we;
    assign first_block  = r_fb;
    assign last_block   = r_lb;
    assign msg_done     = r_done;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level padding model feeding a per-cycle burst checker.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        in_ready;
    logic        core_busy;
    logic [31:0] data;
    logic        write_enable;
    logic        first_block;
    logic        last_block;
    logic        msg_done;

    sha256_msg_padder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
        .core_busy(core_busy), .data(data), .write_enable(write_enable),
        .first_block(first_block), .last_block(last_block), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int bidx = 0;
    bit lead_seen = 1'b0;

    byte unsigned msg_q[$];
    logic [31:0]  exp_w[$];
    bit           exp_f[$];
    bit           exp_l[$];
    logic [31:0]  mdl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard SHA-256 padding on a byte array, then sliced into burst words.
    task automatic model_push();
        byte unsigned    p[$];
        longint unsigned bits;
        int              nblk;
        int              idx;
        logic [31:0]     w;
        bits = 64'(msg_q.size()) * 64'd8;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        mdl.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 16; k++) begin
                idx = b * 64 + k * 4;
                w = {p[idx], p[idx+1], p[idx+2], p[idx+3]};
                mdl.push_back(w);
                exp_w.push_back(w);
                exp_f.push_back((b == 0) && (k == 0));
                exp_l.push_back((b == nblk - 1) && (k == 0));
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_w.delete();
            exp_f.delete();
            exp_l.delete();
            bidx = 0;
            lead_seen = 1'b0;
        end else begin
            if (write_enable) begin
                if (exp_w.size() == 0) begin
                    chk("unexpected_write", {63'd0, write_enable}, 64'd0);
                end else begin
                    logic [31:0] w;
                    bit f, l;
                    w = exp_w.pop_front();
                    f = exp_f.pop_front();
                    l = exp_l.pop_front();
                    chk("data", data, w);
                    chk("first_block", first_block, f);
                    chk("last_block", last_block, l);
                    if (f) chk("first_lead", lead_seen, 1);
                end
                bidx = (bidx + 1) % 16;
                lead_seen = 1'b0;
            end else begin
                if (bidx != 0) chk("burst_bubble", bidx, 0);
                bidx = 0;
                chk("idle_last_block", last_block, 0);
                if (first_block) begin
                    chk("lead_expected", (exp_f.size() > 0) ? exp_f[0] : 1'b0, 1);
                    lead_seen = 1'b1;
                end else begin
                    lead_seen = 1'b0;
                end
            end
            if (msg_done) begin
                done_cnt++;
                chk("done_after_final_word", exp_w.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        logic ok;
        int   t;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_bytes = nb;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 2000) begin
            ok = in_ready;
            tick();
            t++;
        end
        if (!ok) chk("accept_timeout", t, 0);
    endtask

    task automatic send_msg(input byte unsigned junk, input int bubble_at);
        int          n;
        int          nw;
        logic [31:0] d;
        byte unsigned b;
        n  = msg_q.size();
        nw = (n + 3) / 4;
        model_push();
        exp_done++;
        for (int i = 0; i < nw; i++) begin
            d = '0;
            for (int j = 0; j < 4; j++) begin
                b = (i * 4 + j < n) ? msg_q[i*4+j] : junk;
                d = {d[23:0], b};
            end
            if (i == bubble_at) begin
                in_valid = 1'b0;
                repeat (3) tick();
            end
            drive_word(d, (i == nw - 1), 2'(n % 4));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_msg(input int n, input int kind);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back((kind == 0) ? 8'h30 : 8'(i + 1));
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt < exp_done && t < 3000) begin
            tick();
            t++;
        end
        repeat (4) tick();
        chk({name, "_done_count"}, done_cnt, exp_done);
        chk({name, "_drained"}, exp_w.size(), 0);
    endtask

    task automatic count_words(input int want, output int seen);
        int t = 0;
        seen = 0;
        while (seen < want && t < 500) begin
            tick();
            t++;
            if (write_enable) seen++;
        end
    endtask

    initial begin
        int seen;
        int viol;
        reset = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_bytes = '0;
        core_busy = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data", data, 0);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_first_block", first_block, 0);
        chk("rst_last_block", last_block, 0);
        chk("rst_msg_done", msg_done, 0);
        reset = 1'b0;
        chk("ready_low_at_release", in_ready, 0);
        tick();
        chk("ready_after_release", in_ready, 1);

        // 56 bytes of '0': length spills into a second block
        set_msg(56, 0);
        send_msg(8'h00, -1);
        chk("model56_size", mdl.size(), 32);
        chk("model56_w14", mdl[14], 32'h8000_0000);
        chk("model56_w31", mdl[31], 32'h0000_01C0);
        wait_done("s1");

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00, -1);
        chk("model_abc_w0", mdl[0], 32'h6162_6380);
        chk("model_abc_w15", mdl[15], 32'h0000_0018);
        wait_done("s2");

        // 55 bytes: marker shares the last data word, single block
        set_msg(55, 1);
        msg_q[52] = 8'hAA;
        msg_q[53] = 8'hBB;
        msg_q[54] = 8'hCC;
        send_msg(8'h00, -1);
        chk("model55_size", mdl.size(), 16);
        chk("model55_w13", mdl[13], 32'hAABB_CC80);
        chk("model55_w15", mdl[15], 32'h0000_01B8);
        wait_done("s3");

        // 64 bytes with an input bubble mid-fill
        set_msg(64, 1);
        send_msg(8'h00, 5);
        chk("model64_w16", mdl[16], 32'h8000_0000);
        chk("model64_w31", mdl[31], 32'h0000_0200);
        wait_done("s4");

        // "hello": junk in unused lanes must be cleared
        msg_q = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        send_msg(8'h5A, -1);
        chk("model_hello_w1", mdl[1], 32'h6F80_0000);
        chk("model_hello_w15", mdl[15], 32'h0000_0028);
        wait_done("s4b");

        // 62 bytes: marker lands in slot 15 of block 1
        set_msg(62, 1);
        send_msg(8'h77, -1);
        chk("model62_w15", mdl[15], 32'h3D3E_8000);
        chk("model62_w31", mdl[31], 32'h0000_01F0);
        wait_done("s4c");

        // 60 bytes: marker padded into slot 15, length in block 2
        set_msg(60, 1);
        send_msg(8'h00, -1);
        chk("model60_w15", mdl[15], 32'h8000_0000);
        chk("model60_w31", mdl[31], 32'h0000_01E0);
        wait_done("s4d");

        // core busy for 50 cycles between block 1 and block 2
        set_msg(64, 1);
        send_msg(8'h00, -1);
        count_words(16, seen);
        chk("s5_block1_words", seen, 16);
        core_busy = 1'b1;
        viol = 0;
        repeat (50) begin
            tick();
            if (write_enable || in_ready) viol++;
        end
        chk("s5_quiet_while_busy", viol, 0);
        core_busy = 1'b0;
        wait_done("s5");

        // reset during burst word 7, then a clean "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00, -1);
        count_words(8, seen);
        chk("s6_words_before_abort", seen, 8);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_data", data, 0);
        chk("abort_write_enable", write_enable, 0);
        chk("abort_first_block", first_block, 0);
        chk("abort_last_block", last_block, 0);
        chk("abort_msg_done", msg_done, 0);
        chk("abort_in_ready", in_ready, 0);
        exp_done--;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("s6_ready_after_release", in_ready, 1);
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00, -1);
        wait_done("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
